ddr2_port_arbiter: RTL and testbench
====================================

# ddr2_port_arbiter

Two-port arbiter that shares the single client port of the DDR2 `controller` (`c_addr`, `c_data_in`, `c_rd_req`, `c_wr_req`, `c_data_out`, `c_rdy`) between two requesters. It sits between the system masters and `controller`, and runs on the same `clk`. It grants one transaction at a time using round-robin, sequences the controller handshake, and returns read data and a completion pulse to the granted port. A watchdog flags a hung controller.

## Interface
Parameters:
- `ADDR_W`, 26: address width; matches `c_addr`.
- `DATA_W`, 64: data width; matches `c_data_in` and `c_data_out`.
- `TIMEOUT`, 1023: watchdog limit in cycles. Legal range is 1..65535; the counter is 16 bits.

Ports:
- `clk`  in  1  system clock, the same as the controller's `clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request level. Held high until the matching `pX_done`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read. Stable while `pX_req` is high.
- `p0_addr`, `p1_addr`  in  ADDR_W  transaction address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_done`, `p1_done`  out  1  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data. Valid while `pX_done` is high; otherwise holds its last value.
- `gnt`  out  1  index of the current or last granted port.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky watchdog flag. Cleared only by reset.
- `c_addr`  out  ADDR_W  to controller.
- `c_data_in`  out  DATA_W  to controller.
- `c_rd_req`, `c_wr_req`  out  1  to controller.
- `c_data_out`  in  DATA_W  from controller.
- `c_rdy`  in  1  from controller.

## Operation
- **Controller contract:**
  - The controller accepts a request on a clock edge where `c_rdy`=1 and `c_*_req`=1.
  - It drops `c_rdy` within one cycle of accepting and ignores requests while `c_rdy`=0.
  - `c_rdy` rising again marks completion; for reads, `c_data_out` is valid in that cycle.
- **FSM states:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - When `c_rdy`=1 and any unmasked request is present, select a winner.
  - Latch `c_addr`, `c_data_in` and the direction from the winner.
  - Set `gnt`, then go to ISSUE.
  - With `c_rdy`=0, stay in IDLE.
- **ISSUE:** assert `c_rd_req` (if `we`=0) or `c_wr_req` (if `we`=1). Exactly one of them is high. Go to WAIT_BUSY.
- **WAIT_BUSY:** keep the request asserted until `c_rdy`=0 is sampled. Then deassert both requests and go to WAIT_DONE.
- **WAIT_DONE:** on a sampled `c_rdy`=1:
  - capture `c_data_out` into `pGNT_rdata` (reads only);
  - pulse `pGNT_done`;
  - update the round-robin pointer;
  - go to IDLE.
- **Round-robin:**
  - The last-granted port has lowest priority.
  - After reset the pointer is 1, so port 0 wins a simultaneous first request.
  - A lone requester is always granted, regardless of the pointer.
- **Done-cycle mask:** the port whose `done` is high is excluded from arbitration in that same cycle. Its next request can be accepted no earlier than the following cycle, so the requester may drop `req` combinationally from `done`.
- **Withdrawn request:** if `pX_req` falls after grant, the transaction still completes and `done` still pulses.
- **Watchdog:**
  - A 16-bit counter clears on entry to WAIT_BUSY and again on entry to WAIT_DONE, and increments each cycle spent in those states.
  - When it reaches `TIMEOUT`: set `err`, drop both `c_*_req`, pulse `pGNT_done` with `rdata` = 0, and go to IDLE.
- **Reset (asynchronous, any state):**
  - State = IDLE and the pointer = 1.
  - All outputs are 0: `c_*_req`, `c_addr`, `c_data_in`, `pX_done`, `pX_rdata`, `gnt`, `busy`, `err`.
  - The watchdog counter is 0.
  - Any in-flight transaction is abandoned with no `done`.

## Timing
- All outputs are registered.
- **Issue latency:** `req` sampled at edge E0 in IDLE with `c_rdy`=1 → `c_*_req`, `c_addr` and `gnt` valid after E1 (the IDLE→ISSUE and ISSUE transitions each take one edge).
- **Request width:** the request stays high until the edge after `c_rdy`=0 is first sampled. The minimum is 2 cycles when the controller drops `c_rdy` one cycle after acceptance.
- **Completion:** `c_rdy`=1 sampled in WAIT_DONE at edge Ek → `pX_done`=1 and `rdata` valid in cycle k+1. The arbiter is in IDLE that same cycle.
- **Throughput:** back-to-back grants are possible. The next IDLE decision is made at edge Ek+1, and the next request is asserted from Ek+2.
- **Timeout:** `err` rises, and `done` pulses, in the cycle after the counter equals `TIMEOUT`.

## Test plan
- **Single read:** `p0_req`=1, `we`=0, `addr`=0x000123; controller model stays busy 10 cycles and returns 0xDEADBEEF_01234567 → exactly one `c_rd_req` transaction at 0x000123; `p0_done` one cycle; `p0_rdata`=0xDEADBEEF_01234567; `p1_done` stays 0.
- **Contention:** both ports request reads from reset → grant order 0,1,0,1 over four transactions; `gnt` toggles; no port is granted twice in a row while the other waits.
- **Write path:** `p1_we`=1, `p1_wdata`=0xA5A5_5A5A_0F0F_F0F0 → `c_wr_req` high, `c_rd_req` low; `c_data_in` matches the write data; `p1_rdata` unchanged at `done`.
- **Done-cycle mask:** `p0` holds `req` through its `done` cycle while `p1` is idle → the second `p0` grant is asserted no earlier than 2 cycles after `done`; no duplicate issue.
- **Watchdog:** `TIMEOUT`=8; controller never re-raises `c_rdy` → `err`=1 and `p0_done` with `rdata`=0 exactly 9 cycles after entering WAIT_DONE; `err` stays 1 across later transactions.
- **Reset mid-op:** assert `rst_n`=0 during WAIT_DONE → all outputs are 0 immediately, without a clock edge; no `done`; after release, a `p1`-only request is granted.

Source files
------------

// File: rtl/ddr2_port_arbiter.sv
// Two-port round-robin arbiter sharing the DDR2 controller client port.
// Runs one controller transaction at a time, returns data/done to the granted port, watchdogs a hung controller.
module ddr2_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              gnt,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    output logic              c_rd_req,
    output logic              c_wr_req,
    input  logic [DATA_W-1:0] c_data_out,
    input  logic              c_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t            state_r, state_nx_s;
    logic              ptr_r, ptr_nx_s;
    logic              we_r, we_nx_s;
    logic [15:0]       wdog_r, wdog_nx_s;
    logic              gnt_nx_s, busy_nx_s, err_nx_s;
    logic              c_rd_req_nx_s, c_wr_req_nx_s;
    logic              p0_done_nx_s, p1_done_nx_s;
    logic [ADDR_W-1:0] c_addr_nx_s;
    logic [DATA_W-1:0] c_data_in_nx_s, p0_rdata_nx_s, p1_rdata_nx_s;
    logic [1:0]        req_s;
    logic              win_s;
    logic              finish_s, load_rdata_s;
    logic [DATA_W-1:0] fin_rdata_s;

    // The port completing this cycle sits out so it cannot be regranted off a stale req
    assign req_s = {p1_req & ~p1_done, p0_req & ~p0_done};

    // Round-robin pick: the last-granted port loses a tie, a lone requester always wins
    always_comb begin
        win_s = 1'b0;
        case (req_s)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~ptr_r;
            default: win_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic for the controller handshake FSM
    always_comb begin
        state_nx_s     = state_r;
        ptr_nx_s       = ptr_r;
        we_nx_s        = we_r;
        wdog_nx_s      = wdog_r;
        gnt_nx_s       = gnt;
        err_nx_s       = err;
        c_rd_req_nx_s  = c_rd_req;
        c_wr_req_nx_s  = c_wr_req;
        c_addr_nx_s    = c_addr;
        c_data_in_nx_s = c_data_in;
        p0_done_nx_s   = 1'b0;
        p1_done_nx_s   = 1'b0;
        p0_rdata_nx_s  = p0_rdata;
        p1_rdata_nx_s  = p1_rdata;
        finish_s       = 1'b0;
        load_rdata_s   = 1'b0;
        fin_rdata_s    = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (c_rdy && (req_s != 2'b00)) begin
                    gnt_nx_s       = win_s;
                    we_nx_s        = win_s ? p1_we : p0_we;
                    c_addr_nx_s    = win_s ? p1_addr : p0_addr;
                    c_data_in_nx_s = win_s ? p1_wdata : p0_wdata;
                    state_nx_s     = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                c_rd_req_nx_s = ~we_r;
                c_wr_req_nx_s = we_r;
                wdog_nx_s     = 16'd0;
                state_nx_s    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!c_rdy) begin
                    c_rd_req_nx_s = 1'b0;
                    c_wr_req_nx_s = 1'b0;
                    wdog_nx_s     = 16'd0;
                    state_nx_s    = ST_WAIT_DONE;
                end else if (wdog_r == TIMEOUT_C) begin
                    finish_s     = 1'b1;
                    load_rdata_s = 1'b1;
                    err_nx_s     = 1'b1;
                end else begin
                    wdog_nx_s = wdog_r + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (c_rdy) begin
                    finish_s     = 1'b1;
                    load_rdata_s = ~we_r;
                    fin_rdata_s  = c_data_out;
                end else if (wdog_r == TIMEOUT_C) begin
                    finish_s     = 1'b1;
                    load_rdata_s = 1'b1;
                    err_nx_s     = 1'b1;
                end else begin
                    wdog_nx_s = wdog_r + 16'd1;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                c_rd_req_nx_s = 1'b0;
                c_wr_req_nx_s = 1'b0;
            end
        endcase

        // Normal completion and watchdog expiry both retire the transaction the same way
        if (finish_s) begin
            state_nx_s    = ST_IDLE;
            ptr_nx_s      = gnt;
            c_rd_req_nx_s = 1'b0;
            c_wr_req_nx_s = 1'b0;
            p0_done_nx_s  = ~gnt;
            p1_done_nx_s  = gnt;
        end else begin
            p0_done_nx_s = 1'b0;
            p1_done_nx_s = 1'b0;
        end
        if (load_rdata_s) begin
            if (gnt) begin
                p1_rdata_nx_s = fin_rdata_s;
            end else begin
                p0_rdata_nx_s = fin_rdata_s;
            end
        end else begin
            p0_rdata_nx_s = p0_rdata;
            p1_rdata_nx_s = p1_rdata;
        end
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State, pointer, watchdog and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 1'b1;
            we_r      <= 1'b0;
            wdog_r    <= 16'd0;
            gnt       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            c_rd_req  <= 1'b0;
            c_wr_req  <= 1'b0;
            c_addr    <= {ADDR_W{1'b0}};
            c_data_in <= {DATA_W{1'b0}};
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_rdata  <= {DATA_W{1'b0}};
            p1_rdata  <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            ptr_r     <= ptr_nx_s;
            we_r      <= we_nx_s;
            wdog_r    <= wdog_nx_s;
            gnt       <= gnt_nx_s;
            busy      <= busy_nx_s;
            err       <= err_nx_s;
            c_rd_req  <= c_rd_req_nx_s;
            c_wr_req  <= c_wr_req_nx_s;
            c_addr    <= c_addr_nx_s;
            c_data_in <= c_data_in_nx_s;
            p0_done   <= p0_done_nx_s;
            p1_done   <= p1_done_nx_s;
            p0_rdata  <= p0_rdata_nx_s;
            p1_rdata  <= p1_rdata_nx_s;
        end
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Scoreboard bench for ddr2_port_arbiter: directed stimulus pushes expectations,
// negedge monitors compare issues/completions; a second instance with TIMEOUT=8 covers the watchdog.
module tb_ddr2_port_arbiter;

    typedef struct {
        bit          port;
        bit          we;
        logic [25:0] addr;
        logic [63:0] wdata;
        int          gap;
    } iss_t;

    typedef struct {
        bit          port;
        logic [63:0] rdata;
        int          lat;
    } cmp_t;

    typedef struct {
        logic [63:0] rdata;
        bit          err;
        int          gap;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [25:0] p0_addr, p1_addr;
    logic [63:0] p0_wdata, p1_wdata;
    logic        p0_done, p1_done, gnt, busy, err;
    logic [63:0] p0_rdata, p1_rdata;
    logic [25:0] c_addr;
    logic [63:0] c_data_in, c_data_out;
    logic        c_rd_req, c_wr_req, c_rdy;

    logic        w_p0_req;
    logic [25:0] w_p0_addr;
    logic        w_p0_done, w_p1_done, w_gnt, w_busy, w_err;
    logic [63:0] w_p0_rdata, w_p1_rdata;
    logic [25:0] w_c_addr;
    logic [63:0] w_c_data_in, w_c_data_out;
    logic        w_c_rd_req, w_c_wr_req, w_c_rdy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_lat  = 2;
    int w_lat  = 3;
    bit w_hang = 1'b0;

    iss_t        iss_q[$];
    cmp_t        cmp_q[$];
    wexp_t       w_q[$];
    logic [63:0] mdl_q[$];
    logic [63:0] wmdl_q[$];

    ddr2_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .gnt(gnt), .busy(busy), .err(err),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .c_data_out(c_data_out), .c_rdy(c_rdy)
    );

    ddr2_port_arbiter #(.TIMEOUT(8)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .p0_req(w_p0_req), .p0_we(1'b0), .p0_addr(w_p0_addr), .p0_wdata(64'd0),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(26'd0), .p1_wdata(64'd0),
        .p0_done(w_p0_done), .p0_rdata(w_p0_rdata), .p1_done(w_p1_done), .p1_rdata(w_p1_rdata),
        .gnt(w_gnt), .busy(w_busy), .err(w_err),
        .c_addr(w_c_addr), .c_data_in(w_c_data_in), .c_rd_req(w_c_rd_req), .c_wr_req(w_c_wr_req),
        .c_data_out(w_c_data_out), .c_rdy(w_c_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Controller model: accepts on rdy&req, keeps rdy low m_lat cycles, returns data as rdy rises
    logic [63:0] m_data;
    int          m_cnt;
    bit          m_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rdy <= 1'b1; m_busy <= 1'b0; m_cnt <= 0; c_data_out <= 64'd0; m_data <= 64'd0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                c_rdy <= 1'b1; m_busy <= 1'b0; c_data_out <= m_data;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (c_rdy && (c_rd_req || c_wr_req)) begin
            c_rdy <= 1'b0; m_busy <= 1'b1; m_cnt <= m_lat;
            if (mdl_q.size() > 0) m_data <= mdl_q.pop_front();
            else m_data <= 64'd0;
        end
    end

    // Same model for the watchdog instance, with a hang switch that withholds rdy
    logic [63:0] w_data;
    int          w_cnt;
    bit          w_busy_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_c_rdy <= 1'b1; w_busy_m <= 1'b0; w_cnt <= 0; w_c_data_out <= 64'd0; w_data <= 64'd0;
        end else if (w_busy_m) begin
            if (w_cnt <= 1) begin
                if (!w_hang) begin
                    w_c_rdy <= 1'b1; w_busy_m <= 1'b0; w_c_data_out <= w_data;
                end
            end else begin
                w_cnt <= w_cnt - 1;
            end
        end else if (w_c_rdy && (w_c_rd_req || w_c_wr_req)) begin
            w_c_rdy <= 1'b0; w_busy_m <= 1'b1; w_cnt <= w_lat;
            if (wmdl_q.size() > 0) w_data <= wmdl_q.pop_front();
            else w_data <= 64'd0;
        end
    end

    // Main monitor: checks every controller issue and every port completion against the queues
    initial begin : mon_main
        iss_t ie;
        cmp_t ce;
        bit   prev_req;
        int   last_done_cyc, last_iss_cyc;
        prev_req = 1'b0; last_done_cyc = -1000; last_iss_cyc = -1000;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((c_rd_req || c_wr_req) && !prev_req) begin
                    chk("req_onehot", {63'd0, c_rd_req ^ c_wr_req}, 64'd1);
                    if (iss_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_issue: got addr %0h expected none", c_addr);
                    end else begin
                        ie = iss_q.pop_front();
                        chk("issue_gnt", {63'd0, gnt}, {63'd0, ie.port});
                        chk("issue_wr_req", {63'd0, c_wr_req}, {63'd0, ie.we});
                        chk("issue_rd_req", {63'd0, c_rd_req}, {63'd0, ~ie.we});
                        chk("issue_addr", {38'd0, c_addr}, {38'd0, ie.addr});
                        chk("issue_wdata", c_data_in, ie.wdata);
                        chk("issue_busy", {63'd0, busy}, 64'd1);
                        if (ie.gap > 0) chk("issue_gap", 64'(cyc - last_done_cyc), 64'(ie.gap));
                    end
                    last_iss_cyc = cyc;
                end
                if (!(c_rd_req || c_wr_req) && prev_req)
                    chk("req_width", 64'(cyc - last_iss_cyc), 64'd2);
                if (p0_done || p1_done) begin
                    chk("done_onehot", {63'd0, p0_done & p1_done}, 64'd0);
                    chk("done_busy", {63'd0, busy}, 64'd0);
                    if (cmp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got p0_done=%0b p1_done=%0b expected none", p0_done, p1_done);
                    end else begin
                        ce = cmp_q.pop_front();
                        chk("done_port", {63'd0, p1_done}, {63'd0, ce.port});
                        chk("done_rdata", ce.port ? p1_rdata : p0_rdata, ce.rdata);
                        chk("done_latency", 64'(cyc - last_iss_cyc), 64'(ce.lat));
                    end
                    last_done_cyc = cyc;
                end
            end
            prev_req = c_rd_req | c_wr_req;
        end
    end

    // Watchdog-instance monitor: completion data, err flag and cycles since entering WAIT_DONE
    initial begin : mon_wd
        wexp_t we_e;
        bit    prev_req;
        int    entry_cyc;
        prev_req = 1'b0; entry_cyc = -1000;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_req && !w_c_rd_req) entry_cyc = cyc;
                if (w_p0_done) begin
                    if (w_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL wd_unexpected_done: got done expected none");
                    end else begin
                        we_e = w_q.pop_front();
                        chk("wd_rdata", w_p0_rdata, we_e.rdata);
                        chk("wd_err", {63'd0, w_err}, {63'd0, we_e.err});
                        chk("wd_done_gap", 64'(cyc - entry_cyc), 64'(we_e.gap));
                    end
                end
            end
            prev_req = w_c_rd_req;
        end
    end

    task automatic exp_iss(input bit port, input bit we, input logic [25:0] addr,
                           input logic [63:0] wdata, input int gap);
        iss_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.gap = gap;
        iss_q.push_back(e);
    endtask

    task automatic exp_cmp(input bit port, input logic [63:0] rdata, input int lat);
        cmp_t e;
        e.port = port; e.rdata = rdata; e.lat = lat;
        cmp_q.push_back(e);
    endtask

    task automatic exp_wd(input logic [63:0] rdata, input bit e_err, input int gap);
        wexp_t e;
        e.rdata = rdata; e.err = e_err; e.gap = gap;
        w_q.push_back(e);
    endtask

    // Raise a request, hold it until done (bounded), then drop it in the done cycle
    task automatic drive(input bit port, input bit we, input logic [25:0] addr, input logic [63:0] wdata);
        bit seen;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = port ? p1_done : p0_done;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: port %0d got no done expected done within 300 cycles", port);
        end
        if (port) p1_req = 1'b0;
        else p0_req = 1'b0;
    endtask

    task automatic w_drive(input logic [25:0] addr);
        bit seen;
        w_p0_addr = addr; w_p0_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = w_p0_done;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL wd_done_timeout: got no done expected done within 300 cycles");
        end
        w_p0_req = 1'b0;
    endtask

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400000");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        bit seen;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 26'd0; p0_wdata = 64'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 26'd0; p1_wdata = 64'd0;
        w_p0_req = 1'b0; w_p0_addr = 26'd0;
        repeat (2) @(negedge clk);

        chk("rst_c_rd_req", {63'd0, c_rd_req}, 64'd0);
        chk("rst_c_wr_req", {63'd0, c_wr_req}, 64'd0);
        chk("rst_gnt", {63'd0, gnt}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_p0_rdata", p0_rdata, 64'd0);
        chk("rst_w_err", {63'd0, w_err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: pointer starts at 1, so order is 0,1,0,1 back to back
        m_lat = 2;
        mdl_q.push_back(64'h1000_0000_0000_0001);
        mdl_q.push_back(64'h1000_0000_0000_0002);
        mdl_q.push_back(64'h1000_0000_0000_0003);
        mdl_q.push_back(64'h1000_0000_0000_0004);
        exp_iss(1'b0, 1'b0, 26'h0000100, 64'd0, 0);
        exp_iss(1'b1, 1'b0, 26'h0000200, 64'd0, 2);
        exp_iss(1'b0, 1'b0, 26'h0000104, 64'd0, 2);
        exp_iss(1'b1, 1'b0, 26'h0000204, 64'd0, 2);
        exp_cmp(1'b0, 64'h1000_0000_0000_0001, 4);
        exp_cmp(1'b1, 64'h1000_0000_0000_0002, 4);
        exp_cmp(1'b0, 64'h1000_0000_0000_0003, 4);
        exp_cmp(1'b1, 64'h1000_0000_0000_0004, 4);
        fork
            begin
                drive(1'b0, 1'b0, 26'h0000100, 64'd0);
                drive(1'b0, 1'b0, 26'h0000104, 64'd0);
            end
            begin
                drive(1'b1, 1'b0, 26'h0000200, 64'd0);
                drive(1'b1, 1'b0, 26'h0000204, 64'd0);
            end
        join
        repeat (2) @(negedge clk);

        // Single read with a 10-cycle busy controller
        m_lat = 10;
        mdl_q.push_back(64'hDEAD_BEEF_0123_4567);
        exp_iss(1'b0, 1'b0, 26'h0000123, 64'd0, 0);
        exp_cmp(1'b0, 64'hDEAD_BEEF_0123_4567, 12);
        drive(1'b0, 1'b0, 26'h0000123, 64'd0);
        repeat (2) @(negedge clk);

        // Write on port 1: rdata keeps the last read value
        m_lat = 2;
        mdl_q.push_back(64'hFFFF_0000_FFFF_0000);
        exp_iss(1'b1, 1'b1, 26'h00ABCDE, 64'hA5A5_5A5A_0F0F_F0F0, 0);
        exp_cmp(1'b1, 64'h1000_0000_0000_0004, 4);
        drive(1'b1, 1'b1, 26'h00ABCDE, 64'hA5A5_5A5A_0F0F_F0F0);
        repeat (2) @(negedge clk);

        // Port 0 holds req through done: masked for one cycle, regrant issues 3 edges after done
        mdl_q.push_back(64'h5555_5555_5555_5555);
        mdl_q.push_back(64'h6666_6666_6666_6666);
        exp_iss(1'b0, 1'b0, 26'h0000040, 64'd0, 0);
        exp_iss(1'b0, 1'b0, 26'h0000040, 64'd0, 3);
        exp_cmp(1'b0, 64'h5555_5555_5555_5555, 4);
        exp_cmp(1'b0, 64'h6666_6666_6666_6666, 4);
        drive(1'b0, 1'b0, 26'h0000040, 64'd0);
        drive(1'b0, 1'b0, 26'h0000040, 64'd0);
        repeat (2) @(negedge clk);

        // Reset while port 1 sits in WAIT_DONE: outputs clear with no clock edge, no done
        m_lat = 10;
        mdl_q.push_back(64'h7777_7777_7777_7777);
        exp_iss(1'b1, 1'b0, 26'h0000077, 64'd0, 0);
        p1_we = 1'b0; p1_addr = 26'h0000077; p1_wdata = 64'd0; p1_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = c_rd_req;
        end
        for (int i = 0; i < 50 && seen; i++) begin
            @(negedge clk);
            seen = c_rd_req;
        end
        chk("midop_reached_wait_done", {63'd0, busy & ~c_rd_req}, 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_c_rd_req", {63'd0, c_rd_req}, 64'd0);
        chk("arst_c_wr_req", {63'd0, c_wr_req}, 64'd0);
        chk("arst_c_addr", {38'd0, c_addr}, 64'd0);
        chk("arst_c_data_in", c_data_in, 64'd0);
        chk("arst_p0_done", {63'd0, p0_done}, 64'd0);
        chk("arst_p1_done", {63'd0, p1_done}, 64'd0);
        chk("arst_p0_rdata", p0_rdata, 64'd0);
        chk("arst_p1_rdata", p1_rdata, 64'd0);
        chk("arst_gnt", {63'd0, gnt}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        p1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone port-1 request after reset is granted although the pointer favours port 0
        m_lat = 2;
        mdl_q.push_back(64'h8888_8888_8888_8888);
        exp_iss(1'b1, 1'b0, 26'h0000099, 64'd0, 0);
        exp_cmp(1'b1, 64'h8888_8888_8888_8888, 4);
        drive(1'b1, 1'b0, 26'h0000099, 64'd0);
        repeat (2) @(negedge clk);

        // Watchdog instance: normal read, hung controller, then a read after err is set
        w_lat = 3;
        wmdl_q.push_back(64'hCAFE_F00D_1234_5678);
        exp_wd(64'hCAFE_F00D_1234_5678, 1'b0, 3);
        w_drive(26'h0000010);
        repeat (2) @(negedge clk);
        w_hang = 1'b1;
        wmdl_q.push_back(64'h9999_9999_9999_9999);
        exp_wd(64'd0, 1'b1, 9);
        w_drive(26'h0000020);
        w_hang = 1'b0;
        repeat (2) @(negedge clk);
        wmdl_q.push_back(64'hABCD_0000_0000_ABCD);
        exp_wd(64'hABCD_0000_0000_ABCD, 1'b1, 3);
        w_drive(26'h0000030);
        repeat (4) @(negedge clk);

        chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
        chk("cmp_q_drained", 64'(cmp_q.size()), 64'd0);
        chk("wd_q_drained", 64'(w_q.size()), 64'd0);
        chk("main_err_clear", {63'd0, err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
